// File: rtl/birth_scan_ctrl.sv
// Birthday-digit scan sequencer: drives the lookup index and registers the returned digit.
// Optional build macro SCAN_ONESHOT_EN: RUN stops after one full pass (wrap returns to IDLE).
module birth_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DIV        = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       dir,
  output logic [2:0] idx,
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out,
  output logic [7:0] an,
  output logic       valid,
  output logic       wrap,
  output logic       busy
);

  localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [3:0]       digit_out_q, digit_out_d;
  logic [7:0]       an_q, an_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, busy_d;
  logic             chg_q, chg_d;

  logic             do_adv;
  logic [2:0]       adv_base;
  logic [3:0]       adv_res;

  // Returns {wrapped, next_index} for one advance in the given direction.
  function automatic logic [3:0] next_idx(input logic [2:0] cur, input logic down);
    logic [3:0] r;
    if (!down) begin
      r = (cur == IDX_LAST) ? 4'b1000 : {1'b0, cur + 3'd1};
    end else begin
      r = (cur == 3'd0) ? {1'b1, IDX_LAST} : {1'b0, cur - 3'd1};
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    presc_d  = presc_q;
    wrap_d   = 1'b0;
    do_adv   = 1'b0;
    adv_base = idx_q;
    adv_res  = 4'b0000;

    // Command decode, priority stop > start > step.
    case (state_q)
      S_IDLE: begin
        idx_d    = 3'd0;
        adv_base = 3'd0;
        if (!stop) begin
          if (start) begin
            state_d = S_RUN;
            presc_d = '0;
          end else if (step) begin
            do_adv  = 1'b1;
            state_d = S_PAUSE;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_PAUSE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          do_adv  = 1'b1;
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          idx_d   = 3'd0;
          presc_d = '0;
        end else if (start) begin
          state_d = S_RUN;
        end else if (step) begin
          do_adv = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
        presc_d = '0;
      end
    endcase

    if (do_adv) begin
      adv_res = next_idx(adv_base, dir);
      idx_d   = adv_res[2:0];
      wrap_d  = adv_res[3];
`ifdef SCAN_ONESHOT_EN
      // One pass per start: the wrapping auto-advance ends the scan.
      if ((state_q == S_RUN) && adv_res[3]) begin
        state_d = S_IDLE;
        presc_d = '0;
      end
`endif
    end

    // Capture one cycle after idx moves; digit_in already reflects the new idx.
    chg_d       = (idx_d != idx_q);
    valid_d     = chg_q;
    digit_out_d = chg_q ? digit_in : digit_out_q;
    an_d        = chg_q ? (8'b0000_0001 << idx_q) : an_q;
    busy_d      = (state_d == S_RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      presc_q     <= '0;
      digit_out_q <= 4'd0;
      an_q        <= 8'b0000_0001;
      valid_q     <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
      chg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      presc_q     <= presc_d;
      digit_out_q <= digit_out_d;
      an_q        <= an_d;
      valid_q     <= valid_d;
      wrap_q      <= wrap_d;
      busy_q      <= busy_d;
      chg_q       <= chg_d;
    end
  end

  assign idx       = idx_q;
  assign digit_out = digit_out_q;
  assign an        = an_q;
  assign valid     = valid_q;
  assign wrap      = wrap_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_birth_scan_ctrl.sv
// Self-checking bench for birth_scan_ctrl: directed scenarios then random commands vs. a behavioural model.
module tb_birth_scan_ctrl;

  localparam int ND   = 8;
  localparam int DIVV = 4;
`ifdef SCAN_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0, stop = 1'b0, step = 1'b0, dir = 1'b0;
  logic [2:0] idx;
  logic [3:0] digit_in, digit_out;
  logic [7:0] an;
  logic       valid, wrap, busy;

  logic [3:0] lut [8];
  assign digit_in = lut[idx];

  birth_scan_ctrl #(.NUM_DIGITS(ND), .DIV(DIVV), .DIV_W(16)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop), .step(step), .dir(dir),
    .idx(idx), .digit_in(digit_in), .digit_out(digit_out), .an(an),
    .valid(valid), .wrap(wrap), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: 0 = idle, 1 = run, 2 = pause.
  int m_state, m_idx, m_presc;
  bit m_chg;
  logic [2:0] e_idx;
  logic [3:0] e_dout;
  logic [7:0] e_an;
  logic       e_valid, e_wrap, e_busy;

  int errors = 0;
  int checks = 0;
  int wraps_seen = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("idx",       {5'b0, idx},       {5'b0, e_idx});
    chk("wrap",      {7'b0, wrap},      {7'b0, e_wrap});
    chk("busy",      {7'b0, busy},      {7'b0, e_busy});
    chk("valid",     {7'b0, valid},     {7'b0, e_valid});
    chk("digit_out", {4'b0, digit_out}, {4'b0, e_dout});
    chk("an",        an,                e_an);
  endtask

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_presc = 0; m_chg = 1'b0;
    e_idx = 3'd0; e_wrap = 1'b0; e_busy = 1'b0; e_valid = 1'b0;
    e_dout = 4'd0; e_an = 8'h01;
  endtask

  // One rising edge of the reference behaviour, given the commands seen at that edge.
  task automatic model_edge(input bit s, input bit p, input bit t, input bit d);
    int ni, ns, np, base;
    bit adv, w;
    ns = m_state; ni = m_idx; np = m_presc; base = m_idx; adv = 1'b0; w = 1'b0;
    if (m_state == 0) begin
      ni = 0; base = 0;
      if (!p) begin
        if (s) begin ns = 1; np = 0; end
        else if (t) begin adv = 1'b1; ns = 2; end
      end
    end else if (m_state == 1) begin
      if (p) ns = 2;
      else begin
        np = m_presc + 1;
        if (np == DIVV) begin np = 0; adv = 1'b1; end
      end
    end else begin
      if (p) begin ns = 0; ni = 0; np = 0; end
      else if (s) ns = 1;
      else if (t) adv = 1'b1;
    end
    if (adv) begin
      if (!d) begin ni = (base + 1) % ND; w = (ni == 0); end
      else    begin ni = (base + ND - 1) % ND; w = (base == 0); end
      if (ONESHOT && m_state == 1 && w) ns = 0;
    end
    e_valid = m_chg;
    if (m_chg) begin
      e_dout = lut[m_idx];
      e_an   = 8'(1 << m_idx);
    end
    e_idx  = 3'(ni);
    e_wrap = w;
    e_busy = (ns == 1);
    m_chg  = (ni != m_idx);
    m_state = ns; m_idx = ni; m_presc = np;
  endtask

  task automatic cyc(input bit s, input bit p, input bit t, input bit d);
    start = s; stop = p; step = t; dir = d;
    model_edge(s, p, t, d);
    @(posedge CLK);
    #1;
    if (wrap === 1'b1) wraps_seen++;
    check_all();
  endtask

  task automatic idle(input int n, input bit d);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, d);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic reset_mid();
    start = 1'b0; stop = 1'b0; step = 1'b0;
    #3;
    RST = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check_all();
  endtask

  initial begin
    lut[0] = 4'd1; lut[1] = 4'd9; lut[2] = 4'd8; lut[3] = 4'd7;
    lut[4] = 4'd0; lut[5] = 4'd6; lut[6] = 4'd2; lut[7] = 4'd3;
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check_all();

    // Reset while running at idx=5.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 64 && m_idx != 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reach_idx5", {5'b0, idx}, 8'd5);
    reset_mid();

    // Continuous up-scan: two 7->0 wraps within 64 cycles after start.
    wraps_seen = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(64, 1'b0);
`ifndef SCAN_ONESHOT_EN
    chk("wrap_count", 8'(wraps_seen), 8'd2);
`endif
    reset_mid();

    // Paused at 2, step down three times: 1, 0, 7 with wrap on 0->7.
    cyc(1'b0, 1'b0, 1'b1, 1'b0); idle(2, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0); idle(2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      idle(2, 1'b1);
    end
    chk("pause_idx7", {5'b0, idx}, 8'd7);

    // Stop in RUN with prescaler at 2, resume, then stop twice to idle.
    reset_mid();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16 && !(m_state == 1 && m_presc == 2 && m_idx == 1); i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);

    // All three commands together in RUN: pause only.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(6, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b0);
    chk("all_cmds_busy", {7'b0, busy}, 8'd0);

    // Held step advances every cycle; also exercises back-to-back captures.
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);

    // Random commands with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) reset_mid();
      else cyc($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 6,
               $urandom_range(0, 99) < 20, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
